// File: rtl/obstacle_guard.sv
// obstacle_guard
//   Sits between the ultrasonic ranger and the motor driver. It samples the
//   ranger distance once per measurement period and keeps a 4-sample moving
//   average. A hysteretic CLEAR/WARN/STOP state machine runs on that average,
//   and the result gates the forward command and PWM duty arriving from the
//   ESP8266 command path.
//
// Ports
//   clk        in   system clock
//   rst        in   synchronous, active-high reset
//   cm         in   [19:0] ranger distance in cm; 0 = no echo / invalid
//   cmd_in     in   [3:0]  motor command: [0]=fwd [1]=back [2]=left [3]=right
//   speed_in   in   [7:0]  requested PWM duty
//   cmd_out    out  [3:0]  gated motor command (registered)
//   speed_out  out  [7:0]  gated PWM duty (registered)
//   state      out  [1:0]  00=CLEAR 01=WARN 10=STOP (registered)
//   obstacle   out         1 while state is STOP
//   avg_cm     out  [19:0] current moving average (registered)

module obstacle_guard #(
    parameter int unsigned SAMPLE_PERIOD = 50_000_000,
    parameter int unsigned STOP_CM       = 20,
    parameter int unsigned WARN_CM       = 50,
    parameter int unsigned HYST_CM       = 5,
    parameter int unsigned STALE_MAX     = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [19:0] cm,
    input  logic [3:0]  cmd_in,
    input  logic [7:0]  speed_in,
    output logic [3:0]  cmd_out,
    output logic [7:0]  speed_out,
    output logic [1:0]  state,
    output logic        obstacle,
    output logic [19:0] avg_cm
);

    localparam int unsigned CNT_W   = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int unsigned STALE_W = (STALE_MAX > 0) ? $clog2(STALE_MAX + 1) : 1;

    localparam logic [CNT_W-1:0]   TICK_AT   = CNT_W'(SAMPLE_PERIOD - 1);
    localparam logic [STALE_W-1:0] STALE_LIM = STALE_W'(STALE_MAX);
    localparam logic [19:0]        STOP_TH   = 20'(STOP_CM);
    localparam logic [19:0]        WARN_TH   = 20'(WARN_CM);
    localparam logic [19:0]        CLEAR_UP  = 20'(WARN_CM + HYST_CM);
    localparam logic [19:0]        WARN_UP   = 20'(STOP_CM + HYST_CM);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'b00,
        ST_WARN  = 2'b01,
        ST_STOP  = 2'b10
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   tick_cnt;
    logic               tick;
    logic [19:0]        win [4];
    logic [21:0]        sum;
    logic [2:0]         fill_cnt;
    logic [STALE_W-1:0] stale_cnt;
    logic               upd_pend;
    logic               win_full;
    logic [19:0]        avg_new;
    logic [3:0]         cmd_d;
    logic [7:0]         speed_d;

    assign tick     = (tick_cnt == TICK_AT);
    assign win_full = (fill_cnt == 3'd4);
    // Four 20-bit samples always fit the 22-bit sum, so sum>>2 fits 20 bits.
    assign avg_new  = win_full ? 20'(sum >> 2) : '0;

    // Sampling at the tick edge; the average/state follow one cycle later
    // (upd_pend), so a reset in between drops the pending evaluation.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt  <= '0;
            sum       <= '0;
            fill_cnt  <= '0;
            stale_cnt <= '0;
            upd_pend  <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) begin
                win[i] <= '0;
            end
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            upd_pend <= tick;
            if (tick) begin
                if (cm != '0) begin
                    win[0]    <= cm;
                    win[1]    <= win[0];
                    win[2]    <= win[1];
                    win[3]    <= win[2];
                    // Oldest entry is always part of sum, so no underflow.
                    sum       <= sum + {2'b00, cm} - {2'b00, win[3]};
                    stale_cnt <= '0;
                    if (!win_full) begin
                        fill_cnt <= fill_cnt + 3'd1;
                    end
                end else if (stale_cnt != STALE_LIM) begin
                    stale_cnt <= stale_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            avg_cm <= '0;
        end else if (upd_pend) begin
            avg_cm <= avg_new;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_STOP;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: evaluated only in the cycle the new average is registered,
    // which limits the machine to one transition per tick.
    always_comb begin
        state_d = state_q;
        if (upd_pend) begin
            if (!win_full || (stale_cnt == STALE_LIM)) begin
                state_d = ST_STOP;
            end else begin
                unique case (state_q)
                    ST_CLEAR: begin
                        if (avg_new < STOP_TH) begin
                            state_d = ST_STOP;
                        end else if (avg_new < WARN_TH) begin
                            state_d = ST_WARN;
                        end
                    end
                    ST_WARN: begin
                        if (avg_new < STOP_TH) begin
                            state_d = ST_STOP;
                        end else if (avg_new >= CLEAR_UP) begin
                            state_d = ST_CLEAR;
                        end
                    end
                    ST_STOP: begin
                        if (avg_new >= CLEAR_UP) begin
                            state_d = ST_CLEAR;
                        end else if (avg_new >= WARN_UP) begin
                            state_d = ST_WARN;
                        end
                    end
                    default: state_d = ST_STOP;
                endcase
            end
        end
    end

    // Output gating from the current state
    always_comb begin
        cmd_d   = cmd_in;
        speed_d = speed_in;
        if (cmd_in[0] && cmd_in[1]) begin
            cmd_d   = '0;
            speed_d = '0;
        end else begin
            unique case (state_q)
                ST_CLEAR: ;
                ST_WARN:  speed_d = speed_in >> 1;
                ST_STOP: begin
                    cmd_d   = cmd_in & 4'b1110;
                    speed_d = cmd_in[1] ? speed_in : '0;
                end
                default: begin
                    cmd_d   = '0;
                    speed_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_out   <= '0;
            speed_out <= '0;
        end else begin
            cmd_out   <= cmd_d;
            speed_out <= speed_d;
        end
    end

    assign state    = state_q;
    assign obstacle = (state_q == ST_STOP);

endmodule

// File: tb/tb_obstacle_guard.sv
// tb_obstacle_guard
//   Directed scenarios for obstacle_guard with a short sample period. The
//   stimulus process queues the expected outputs together with the absolute
//   cycle at which they must appear; a monitor process compares them.

module tb_obstacle_guard;

    localparam int unsigned SP  = 16;
    localparam logic [1:0]  CLR = 2'b00;
    localparam logic [1:0]  WRN = 2'b01;
    localparam logic [1:0]  STP = 2'b10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [19:0] cm = '0;
    logic [3:0]  cmd_in = '0;
    logic [7:0]  speed_in = '0;
    logic [3:0]  cmd_out;
    logic [7:0]  speed_out;
    logic [1:0]  state;
    logic        obstacle;
    logic [19:0] avg_cm;

    obstacle_guard #(.SAMPLE_PERIOD(SP)) dut (
        .clk       (clk),
        .rst       (rst),
        .cm        (cm),
        .cmd_in    (cmd_in),
        .speed_in  (speed_in),
        .cmd_out   (cmd_out),
        .speed_out (speed_out),
        .state     (state),
        .obstacle  (obstacle),
        .avg_cm    (avg_cm)
    );

    always #5 clk = ~clk;

    // cyc: edges since the last reset edge; abs_cyc: free-running edge count
    int unsigned cyc = 0;
    int unsigned abs_cyc = 0;
    always @(posedge clk) begin
        abs_cyc <= abs_cyc + 1;
        cyc     <= rst ? 0 : cyc + 1;
    end

    typedef struct {
        int unsigned at;
        string       name;
        logic [1:0]  st;
        logic [19:0] avg;
        logic [3:0]  cmd;
        logic [7:0]  spd;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   fails  = 0;

    task automatic push(input string nm, input int unsigned at, input logic [1:0] st,
                        input logic [19:0] avg, input logic [3:0] c, input logic [7:0] s);
        exp_t x;
        x.at = at; x.name = nm; x.st = st; x.avg = avg; x.cmd = c; x.spd = s;
        sb.push_back(x);
    endtask

    // Monitor
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].at <= abs_cyc) begin
            e = sb.pop_front();
            checks++;
            if (e.at < abs_cyc) begin
                fails++;
                $display("FAIL %s: check slot cycle %0d missed (now %0d)", e.name, e.at, abs_cyc);
            end else if (state !== e.st || obstacle !== (e.st == STP) || avg_cm !== e.avg ||
                         cmd_out !== e.cmd || speed_out !== e.spd) begin
                fails++;
                $display("FAIL %s: got state=%b obst=%b avg=%0d cmd=%b spd=%0d, want state=%b obst=%b avg=%0d cmd=%b spd=%0d",
                         e.name, state, obstacle, avg_cm, cmd_out, speed_out,
                         e.st, (e.st == STP), e.avg, e.cmd, e.spd);
            end
        end
    end

    // One measurement: cm is junk except in the tick cycle, so off-tick
    // changes must be ignored. Returns at cycle 16n+3, after the check slot.
    task automatic tick(input string nm, input logic [19:0] v, input logic [1:0] st,
                        input logic [19:0] avg, input logic [3:0] c, input logic [7:0] s);
        int unsigned n;
        n  = cyc / SP + 1;
        cm = 20'd3;
        while (cyc != SP * n - 1) @(negedge clk);
        cm = v;
        @(negedge clk);
        cm = 20'd3;
        push(nm, abs_cyc + 2, st, avg, c, s);
        while (cyc != SP * n + 3) @(negedge clk);
    endtask

    task automatic set_cmd(input string nm, input logic [3:0] c, input logic [7:0] s,
                           input logic [1:0] st, input logic [19:0] avg,
                           input logic [3:0] ec, input logic [7:0] es);
        cmd_in   = c;
        speed_in = s;
        push(nm, abs_cyc + 1, st, avg, ec, es);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input string nm);
        rst = 1'b1;
        push(nm, abs_cyc + 1, STP, 20'd0, 4'd0, 8'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cmd_in   = 4'b0001;
        speed_in = 8'd200;
        @(negedge clk);
        do_reset("reset");

        // 1: fill the window
        tick("s1_t1", 20'd100, STP, 20'd0,   4'b0000, 8'd0);
        tick("s1_t2", 20'd100, STP, 20'd0,   4'b0000, 8'd0);
        tick("s1_t3", 20'd100, STP, 20'd0,   4'b0000, 8'd0);
        tick("s1_t4", 20'd100, CLR, 20'd100, 4'b0001, 8'd200);

        // 2: approach to WARN
        tick("s2_t1", 20'd40, CLR, 20'd85, 4'b0001, 8'd200);
        tick("s2_t2", 20'd40, CLR, 20'd70, 4'b0001, 8'd200);
        tick("s2_t3", 20'd40, CLR, 20'd55, 4'b0001, 8'd200);
        tick("s2_t4", 20'd40, WRN, 20'd40, 4'b0001, 8'd100);

        // 3: approach to STOP
        tick("s3_t1", 20'd10, WRN, 20'd32, 4'b0001, 8'd100);
        tick("s3_t2", 20'd10, WRN, 20'd25, 4'b0001, 8'd100);
        tick("s3_t3", 20'd10, STP, 20'd17, 4'b0000, 8'd0);
        tick("s3_t4", 20'd10, STP, 20'd10, 4'b0000, 8'd0);
        set_cmd("s3_back", 4'b0010, 8'd200, STP, 20'd10, 4'b0010, 8'd200);
        set_cmd("s3_fwd",  4'b0001, 8'd200, STP, 20'd10, 4'b0000, 8'd0);

        // 4: hysteresis out of STOP (window 10,10,10,10)
        tick("s4_avg22", 20'd58,  STP, 20'd22, 4'b0000, 8'd0);
        tick("s4_avg25", 20'd22,  WRN, 20'd25, 4'b0001, 8'd100);
        tick("s4_avg52", 20'd118, WRN, 20'd52, 4'b0001, 8'd100);
        tick("s4_avg55", 20'd22,  CLR, 20'd55, 4'b0001, 8'd200);

        // 5: stale (no-echo) samples
        tick("s5_z1", 20'd0,   CLR, 20'd55, 4'b0001, 8'd200);
        tick("s5_z2", 20'd0,   CLR, 20'd55, 4'b0001, 8'd200);
        tick("s5_z3", 20'd0,   STP, 20'd55, 4'b0000, 8'd0);
        tick("s5_ok", 20'd100, CLR, 20'd65, 4'b0001, 8'd200);

        // 6: illegal command, then reset with an evaluation pending
        set_cmd("s6_illegal", 4'b0011, 8'd200, CLR, 20'd65, 4'b0000, 8'd0);
        set_cmd("s6_legal",   4'b0001, 8'd200, CLR, 20'd65, 4'b0001, 8'd200);
        while (cyc % SP != 0) @(negedge clk);
        do_reset("s6_rst_mid");
        tick("s6_t1", 20'd100, STP, 20'd0,   4'b0000, 8'd0);
        tick("s6_t2", 20'd100, STP, 20'd0,   4'b0000, 8'd0);
        tick("s6_t3", 20'd100, STP, 20'd0,   4'b0000, 8'd0);
        tick("s6_t4", 20'd100, CLR, 20'd100, 4'b0001, 8'd200);

        repeat (4) @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            fails++;
            $display("FAIL %s: expectation never checked (slot %0d, now %0d)", e.name, e.at, abs_cyc);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
